// File: rtl/spi_slave_mem_burst.sv
// SPI slave with an on-chip word memory: 2-bit command, address/data payloads
// shifted MSB first on clk, optional auto-increment bursts within one SS_n frame.
module spi_slave_mem_burst #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter int AUTO_INC   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic miso_en,
    output logic wr_done,
    output logic frame_err
);
    localparam int SW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] AW_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DW_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] DW_FULL = CW'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam bit BURST = (AUTO_INC != 0);

    typedef enum logic [2:0] {IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, HOLD} state_t;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == TOP_ADDR) ? '0 : a + 1'b1;
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_X;
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];
    state_t                state_reg;
    logic [SW-1:0]         shift_reg;
    logic [CW-1:0]         bit_cnt_reg;
    logic                  cmd_hi_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg, rd_addr_reg;
    logic [DATA_WIDTH-1:0] rd_word_reg;
    logic                  rd_ok_reg;

    logic [ADDR_WIDTH-1:0] rd_fetch, rd_idx, addr_word;
    logic [DATA_WIDTH-1:0] wr_word, rd_word_out;
    logic                  mem_we;

    // While streaming, prefetch the following word so a burst reload has no gap.
    assign rd_fetch    = (state_reg == RD_DATA) ? addr_inc(rd_addr_reg) : rd_addr_reg;
    assign rd_idx      = in_range(rd_fetch) ? rd_fetch : '0;
    assign rd_word_out = rd_ok_reg ? rd_word_reg : '0;
    assign wr_word     = {shift_reg[DATA_WIDTH-2:0], MOSI};
    assign addr_word   = {shift_reg[ADDR_WIDTH-2:0], MOSI};
    assign mem_we      = !rst && !SS_n && (state_reg == WR_DATA) &&
                         (bit_cnt_reg == DW_LAST) && in_range(wr_addr_reg);

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_addr_reg] <= wr_word;
        rd_word_reg <= mem[rd_idx];
        rd_ok_reg   <= in_range(rd_fetch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            MISO        <= 1'b0;
            miso_en     <= 1'b0;
            wr_done     <= 1'b0;
            frame_err   <= 1'b0;
            wr_addr_reg <= '0;
            rd_addr_reg <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            cmd_hi_reg  <= 1'b0;
        end else begin
            wr_done   <= 1'b0;
            frame_err <= 1'b0;
            if (SS_n) begin
                state_reg   <= IDLE;
                MISO        <= 1'b0;
                miso_en     <= 1'b0;
                bit_cnt_reg <= '0;
                if (state_reg == CMD ||
                    ((state_reg == WR_ADDR || state_reg == RD_ADDR || state_reg == WR_DATA) &&
                     bit_cnt_reg != '0))
                    frame_err <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg   <= CMD;
                        bit_cnt_reg <= '0;
                    end
                    CMD: begin
                        if (bit_cnt_reg == '0) begin
                            cmd_hi_reg  <= MOSI;
                            bit_cnt_reg <= CW'(1);
                        end else begin
                            bit_cnt_reg <= '0;
                            case ({cmd_hi_reg, MOSI})
                                2'b00:   state_reg <= WR_ADDR;
                                2'b01:   state_reg <= WR_DATA;
                                2'b10:   state_reg <= RD_ADDR;
                                default: state_reg <= RD_DATA;
                            endcase
                        end
                    end
                    WR_ADDR, RD_ADDR: begin
                        shift_reg <= {shift_reg[SW-2:0], MOSI};
                        if (bit_cnt_reg == AW_LAST) begin
                            if (state_reg == WR_ADDR)
                                wr_addr_reg <= addr_word;
                            else
                                rd_addr_reg <= addr_word;
                            state_reg   <= HOLD;
                            bit_cnt_reg <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    WR_DATA: begin
                        shift_reg <= {shift_reg[SW-2:0], MOSI};
                        if (bit_cnt_reg == DW_LAST) begin
                            wr_done     <= 1'b1;
                            bit_cnt_reg <= '0;
                            if (BURST)
                                wr_addr_reg <= addr_inc(wr_addr_reg);
                            else
                                state_reg <= HOLD;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    RD_DATA: begin
                        // bit_cnt_reg counts bits already presented on MISO for this word
                        if (bit_cnt_reg == '0 || (bit_cnt_reg == DW_FULL && BURST)) begin
                            if (bit_cnt_reg != '0)
                                rd_addr_reg <= addr_inc(rd_addr_reg);
                            MISO        <= rd_word_out[DATA_WIDTH-1];
                            miso_en     <= 1'b1;
                            shift_reg   <= SW'({rd_word_out[DATA_WIDTH-2:0], 1'b0});
                            bit_cnt_reg <= CW'(1);
                        end else if (bit_cnt_reg == DW_FULL) begin
                            MISO        <= 1'b0;
                            miso_en     <= 1'b0;
                            state_reg   <= HOLD;
                            bit_cnt_reg <= '0;
                        end else begin
                            MISO        <= shift_reg[DATA_WIDTH-1];
                            shift_reg   <= shift_reg << 1;
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                    HOLD: ;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_mem_burst.sv
// Bench for spi_slave_mem_burst: three configurations (burst/256, single/256,
// burst/200) driven by frames whose expected outputs come from a word-level model.
module tb_spi_slave_mem_burst;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic ss_n [3];
    logic mosi [3];
    logic miso [3];
    logic en   [3];
    logic wd   [3];
    logic fe   [3];

    spi_slave_mem_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1)) dut0 (
        .clk(clk), .rst(rst), .SS_n(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .miso_en(en[0]), .wr_done(wd[0]), .frame_err(fe[0]));
    spi_slave_mem_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(0)) dut1 (
        .clk(clk), .rst(rst), .SS_n(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .miso_en(en[1]), .wr_done(wd[1]), .frame_err(fe[1]));
    spi_slave_mem_burst #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1)) dut2 (
        .clk(clk), .rst(rst), .SS_n(ss_n[2]), .MOSI(mosi[2]),
        .MISO(miso[2]), .miso_en(en[2]), .wr_done(wd[2]), .frame_err(fe[2]));

    int   depth_of [3] = '{256, 256, 200};
    bit   inc_of   [3] = '{1'b1, 1'b0, 1'b1};

    // word-level model of each instance
    logic [7:0] mmem [3][256];
    logic [7:0] m_wa [3];
    logic [7:0] m_ra [3];

    logic exp_miso [3];
    logic exp_en   [3];
    logic exp_wd   [3];
    logic exp_fe   [3];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    logic [15:0] cap [3];
    int   wd_cnt [3];
    int   fe_cnt [3];
    int   en_cnt [3];

    string       lit_name;
    logic [15:0] lit_act, lit_exp;
    int          lit_seq = 0;
    int          lit_seen = 0;

    logic [7:0] pl_q [$];

    task automatic cmp_bit(input string name, input int i, input logic act, input logic expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0t: got %b want %b", name, i, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                cmp_bit("miso", i, miso[i], exp_miso[i]);
                cmp_bit("miso_en", i, en[i], exp_en[i]);
                cmp_bit("wr_done", i, wd[i], exp_wd[i]);
                cmp_bit("frame_err", i, fe[i], exp_fe[i]);
                if (en[i] === 1'b1) begin
                    cap[i] = {cap[i][14:0], miso[i]};
                    en_cnt[i]++;
                end
                if (wd[i] === 1'b1) wd_cnt[i]++;
                if (fe[i] === 1'b1) fe_cnt[i]++;
            end
        end
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            n_cmp++;
            if (lit_act !== lit_exp) begin
                n_bad++;
                $display("FAIL %s: got %0h want %0h", lit_name, lit_act, lit_exp);
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] expv);
        lit_name = name;
        lit_act  = act;
        lit_exp  = expv;
        lit_seq++;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] mword(input int i, input logic [7:0] a);
        return (int'(a) < depth_of[i]) ? mmem[i][a] : 8'h00;
    endfunction

    function automatic logic [7:0] minc(input int i, input logic [7:0] a);
        return (int'(a) == depth_of[i] - 1) ? 8'h00 : a + 8'h01;
    endfunction

    task automatic step(input int i, input logic ss, input logic mo,
                        input logic em, input logic ee, input logic ew, input logic ef);
        ss_n[i] = ss;
        mosi[i] = mo;
        @(posedge clk);
        exp_miso[i] = em;
        exp_en[i]   = ee;
        exp_wd[i]   = ew;
        exp_fe[i]   = ef;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 3; i++) begin
                ss_n[i] = 1'($urandom);
                mosi[i] = 1'($urandom);
            end
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                exp_miso[i] = 1'b0; exp_en[i] = 1'b0; exp_wd[i] = 1'b0; exp_fe[i] = 1'b0;
            end
            chk_on = 1'b1;
            #1;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ss_n[i] = 1'b1;
            m_wa[i] = 8'h00;
            m_ra[i] = 8'h00;
        end
        @(posedge clk);
        #1;
    endtask

    // One SS_n frame: cmd, then nbits payload bits taken MSB first from pl_q;
    // nbits < 0 raises SS_n after the first command bit.
    task automatic frame(input int i, input logic [1:0] cmd, input int nbits);
        logic [7:0] cur, w;
        logic       bitv, em, ee, ew, ef;
        step(i, 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        step(i, 1'b0, cmd[1], 1'b0, 1'b0, 1'b0, 1'b0);
        if (nbits < 0) begin
            step(i, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
            step(i, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        step(i, 1'b0, cmd[0], 1'b0, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < nbits; p++) begin
            em = 1'b0; ee = 1'b0; ew = 1'b0;
            if (cmd == 2'b11) begin
                bitv = 1'($urandom);
            end else begin
                cur  = pl_q[p / 8];
                bitv = cur[7 - (p % 8)];
            end
            case (cmd)
                2'b00: if (p == 7) m_wa[i] = pl_q[0];
                2'b10: if (p == 7) m_ra[i] = pl_q[0];
                2'b01: if ((inc_of[i] || p < 8) && (p % 8 == 7)) begin
                    w = pl_q[p / 8];
                    if (int'(m_wa[i]) < depth_of[i]) mmem[i][m_wa[i]] = w;
                    ew = 1'b1;
                    if (inc_of[i]) m_wa[i] = minc(i, m_wa[i]);
                end
                default: if (inc_of[i] || p < 8) begin
                    if (p % 8 == 0 && p > 0) m_ra[i] = minc(i, m_ra[i]);
                    w  = mword(i, m_ra[i]);
                    em = w[7 - (p % 8)];
                    ee = 1'b1;
                end
            endcase
            step(i, 1'b0, bitv, em, ee, ew, 1'b0);
        end
        case (cmd)
            2'b00, 2'b10: ef = (nbits > 0 && nbits < 8);
            2'b01:        ef = inc_of[i] ? (nbits % 8 != 0) : (nbits > 0 && nbits < 8);
            default:      ef = 1'b0;
        endcase
        step(i, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, ef);
        step(i, 1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_addr(input int i, input logic [1:0] cmd, input logic [7:0] a);
        pl_q = {a};
        frame(i, cmd, 8);
    endtask

    task automatic write1(input int i, input logic [7:0] d);
        pl_q = {d};
        frame(i, 2'b01, 8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, r, i, nb;
        logic [1:0] cmd;
        for (int k = 0; k < 3; k++) begin
            ss_n[k] = 1'b1; mosi[k] = 1'b0; cap[k] = '0;
            wd_cnt[k] = 0; fe_cnt[k] = 0; en_cnt[k] = 0;
            exp_miso[k] = 1'b0; exp_en[k] = 1'b0; exp_wd[k] = 1'b0; exp_fe[k] = 1'b0;
        end
        do_reset();

        // preload every memory through the SPI port itself
        set_addr(0, 2'b00, 8'h00);
        pl_q = {};
        for (int a = 0; a < 256; a++) pl_q.push_back(8'($urandom));
        frame(0, 2'b01, 2048);
        for (int a = 0; a < 256; a++) begin
            set_addr(1, 2'b00, 8'(a));
            write1(1, 8'($urandom));
        end
        set_addr(2, 2'b00, 8'h00);
        pl_q = {};
        for (int a = 0; a < 200; a++) pl_q.push_back(8'($urandom));
        frame(2, 2'b01, 1600);

        // reset with random pins must leave memory intact
        do_reset();
        frame(0, 2'b11, 2048);

        // single write then burst-advanced address
        base = wd_cnt[0];
        set_addr(0, 2'b00, 8'h10);
        write1(0, 8'hA5);
        lit("t2_wr_done_pulses", 16'(wd_cnt[0] - base), 16'd1);
        lit("t2_model_wr_addr", {8'h00, m_wa[0]}, 16'h0011);
        write1(0, 8'h3C);
        set_addr(0, 2'b10, 8'h10);
        frame(0, 2'b11, 16);
        lit("t2_read_10_11", cap[0], 16'hA53C);

        // burst write across the top of memory
        base = wd_cnt[0];
        set_addr(0, 2'b00, 8'hFF);
        pl_q = {8'h11, 8'h22};
        frame(0, 2'b01, 16);
        lit("t3_wr_done_pulses", 16'(wd_cnt[0] - base), 16'd2);
        set_addr(0, 2'b10, 8'hFF);
        frame(0, 2'b11, 16);
        lit("t3_read_ff_wrap", cap[0], 16'h1122);

        // single-word read stops after one word
        set_addr(1, 2'b00, 8'h10);
        write1(1, 8'hA5);
        set_addr(1, 2'b10, 8'h10);
        base = en_cnt[1];
        frame(1, 2'b11, 16);
        lit("t4_miso_en_cycles", 16'(en_cnt[1] - base), 16'd8);
        lit("t4_read_word", {8'h00, cap[1][7:0]}, 16'h00A5);

        // aborted data payload and aborted command
        set_addr(0, 2'b00, 8'h40);
        write1(0, 8'h77);
        set_addr(0, 2'b00, 8'h40);
        base = fe_cnt[0];
        pl_q = {8'hC3};
        frame(0, 2'b01, 5);
        lit("t5_frame_err_pulses", 16'(fe_cnt[0] - base), 16'd1);
        set_addr(0, 2'b10, 8'h40);
        frame(0, 2'b11, 8);
        lit("t5_mem_unchanged", {8'h00, cap[0][7:0]}, 16'h0077);
        write1(0, 8'h3D);
        frame(0, 2'b11, 8);
        lit("t5_next_write", {8'h00, cap[0][7:0]}, 16'h003D);
        base = fe_cnt[0];
        frame(0, 2'b00, -1);
        lit("t5_cmd_abort_err", 16'(fe_cnt[0] - base), 16'd1);

        // beyond MEM_DEPTH: write dropped, read returns zero
        base = wd_cnt[2];
        set_addr(2, 2'b00, 8'hF0);
        write1(2, 8'h5A);
        lit("t6_wr_done_pulses", 16'(wd_cnt[2] - base), 16'd1);
        set_addr(2, 2'b10, 8'hF0);
        frame(2, 2'b11, 16);
        lit("t6_read_oor", cap[2], 16'h0000);
        set_addr(2, 2'b10, 8'hC7);
        frame(2, 2'b11, 16);
        lit("t6_read_wrap_c7_00", {8'h00, cap[2][7:0]}, {8'h00, mmem[2][0]});

        // randomized frames against the model
        for (int n = 0; n < 150; n++) begin
            i   = $urandom_range(0, 2);
            cmd = 2'($urandom);
            r   = $urandom_range(0, 5);
            pl_q = {};
            for (int b = 0; b < 6; b++) pl_q.push_back(8'($urandom));
            case (cmd)
                2'b00, 2'b10: nb = (r == 0) ? -1 : (r == 1) ? $urandom_range(1, 7) : 8 + $urandom_range(0, 3);
                2'b01: begin
                    if (r == 0)      nb = $urandom_range(1, 7);
                    else if (r == 1) nb = -1;
                    else if (inc_of[i]) nb = 8 * $urandom_range(1, 5) + (($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0);
                    else             nb = 8 + $urandom_range(0, 4);
                end
                default: nb = (r == 0) ? -1 : $urandom_range(0, 40);
            endcase
            frame(i, cmd, nb);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
